prs_checker: RTL and testbench

// Self-synchronising PRS checker/BER counter: downstream consumer of the testbench PRS source, placed after the

---
 rtl/prs_pkg.sv | 6 +
 rtl/prs_checker_if.sv | 17 +
 rtl/prs_sat_cnt.sv | 17 +
 rtl/prs_checker.sv | 111 +++++++++++
 tb/tb_prs_checker.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/prs_pkg.sv
// Shared definitions for the PRS checker and the matching PRS generator.
package prs_pkg;
  typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} prs_chk_st_t;
  localparam int PRS_LAG_A = 2;
  localparam int PRS_LAG_B = 16;
endpackage

// File: rtl/prs_checker_if.sv
// Bundle of the received bit stream and the checker status/count outputs.
interface prs_checker_if #(parameter int CNT_W = 32);
  // Handshake: no ready; i_sym is consumed on every cycle with i_vld=1, and the checker always accepts.
  logic             i_vld;
  logic             i_sym;
  logic             i_clr;
  logic             o_lock;
  logic             o_err;
  logic             o_loss;
  logic [CNT_W-1:0] o_bit_cnt;
  logic [CNT_W-1:0] o_err_cnt;

  modport master (output i_vld, i_sym, i_clr,
                  input  o_lock, o_err, o_loss, o_bit_cnt, o_err_cnt);
  modport slave  (input  i_vld, i_sym, i_clr,
                  output o_lock, o_err, o_loss, o_bit_cnt, o_err_cnt);
endinterface

// File: rtl/prs_sat_cnt.sv
// Counter with synchronous clear (priority over enable) that holds at MAX instead of wrapping.
module prs_sat_cnt #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (!reset_n)                 cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (en && (cnt != MAX))  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/prs_checker.sv
// Self-synchronising checker for b[n]=b[n-LAG_A]^b[n-LAG_B]: hunts, syncs, then counts bit errors while locked.
module prs_checker
  import prs_pkg::*;
#(
  parameter int LAG_A    = PRS_LAG_A,
  parameter int LAG_B    = PRS_LAG_B,
  parameter int LOCK_N   = 32,
  parameter int WIN      = 256,
  parameter int LOSS_ERR = 32,
  parameter int CNT_W    = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  prs_checker_if.slave bus,
  output prs_chk_st_t  dbg_state
);
  localparam int FILL_W  = $clog2(LAG_B + 1);
  localparam int MATCH_W = $clog2(LOCK_N + 1);
  localparam int WCNT_W  = $clog2(WIN + 1);
  localparam int WERR_W  = $clog2(LOSS_ERR + 1);
  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(LAG_B - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_N - 1);
  localparam logic [WCNT_W-1:0]  WIN_LAST   = WCNT_W'(WIN - 1);
  localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(LOSS_ERR - 1);

  prs_chk_st_t        state_q, state_d;
  logic [LAG_B-1:0]   hist;
  logic [FILL_W-1:0]  fill;
  logic [MATCH_W-1:0] match;
  logic [WCNT_W-1:0]  win_cnt;
  logic [WERR_W-1:0]  win_err;

  logic exp_bit, hit, match_hit, next_zero, loss_hit, win_wrap;
  logic in_lock, bit_en, err_en, win_clr, new_bit;

  assign exp_bit   = hist[LAG_A-1] ^ hist[LAG_B-1];
  assign hit       = (bus.i_sym == exp_bit);
  assign match_hit = bus.i_vld && hit && (match == MATCH_LAST);
  assign next_zero = ({hist[LAG_B-2:0], bus.i_sym} == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= HUNT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (bus.i_vld && (fill == FILL_LAST)) state_d = SYNC;
      // An all-zero history satisfies the recurrence trivially; refuse to lock on it.
      SYNC:    if (match_hit && !next_zero)          state_d = LOCKED;
      LOCKED:  if (loss_hit)                         state_d = HUNT;
      default:                                       state_d = HUNT;
    endcase
  end

  always_comb begin
    in_lock  = (state_q == LOCKED);
    bit_en   = bus.i_vld && in_lock;
    err_en   = bit_en && !hit;
    loss_hit = err_en && (win_err == WERR_LAST);
    win_wrap = bit_en && (win_cnt == WIN_LAST);
    win_clr  = ((state_q == SYNC) && (state_d == LOCKED)) || win_wrap || loss_hit;
    // Flywheel: once locked the history follows its own prediction, so channel errors do not propagate.
    new_bit  = in_lock ? exp_bit : bus.i_sym;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist       <= '0;
      fill       <= '0;
      match      <= '0;
      win_cnt    <= '0;
      bus.o_err  <= 1'b0;
      bus.o_loss <= 1'b0;
    end else begin
      bus.o_err  <= err_en;
      bus.o_loss <= loss_hit;
      if (bus.i_vld) hist <= {hist[LAG_B-2:0], new_bit};
      case (state_q)
        HUNT: begin
          match <= '0;
          if (bus.i_vld) fill <= fill + 1'b1;
        end
        SYNC: begin
          if (bus.i_vld) match <= (hit && !match_hit) ? match + 1'b1 : '0;
          if (state_d == LOCKED) win_cnt <= '0;
        end
        LOCKED: begin
          if (loss_hit)      fill    <= '0;
          if (win_wrap)      win_cnt <= '0;
          else if (bit_en)   win_cnt <= win_cnt + 1'b1;
        end
        default: fill <= '0;
      endcase
    end
  end

  prs_sat_cnt #(.W(CNT_W)) u_bit_cnt (
    .clk(clk), .reset_n(reset_n), .clr(bus.i_clr), .en(bit_en), .cnt(bus.o_bit_cnt)
  );
  prs_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .reset_n(reset_n), .clr(bus.i_clr), .en(err_en), .cnt(bus.o_err_cnt)
  );
  prs_sat_cnt #(.W(WERR_W), .MAX(WERR_W'(LOSS_ERR))) u_win_err (
    .clk(clk), .reset_n(reset_n), .clr(win_clr), .en(err_en), .cnt(win_err)
  );

  assign bus.o_lock = in_lock;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_prs_checker.sv
// Bench for prs_checker: PRS loopback scenarios plus random traffic, checked against a queue-based model.
module tb_prs_checker;
  import prs_pkg::*;

  localparam int LAG_A    = 2;
  localparam int LAG_B    = 16;
  localparam int LOCK_N   = 32;
  localparam int WIN      = 256;
  localparam int LOSS_ERR = 32;
  localparam int CNT_W    = 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  prs_checker_if #(.CNT_W(CNT_W)) bus();
  prs_chk_st_t dbg_state;

  prs_checker #(
    .LAG_A(LAG_A), .LAG_B(LAG_B), .LOCK_N(LOCK_N),
    .WIN(WIN), .LOSS_ERR(LOSS_ERR), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  string scen = "init";

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s/%s: got %0d want %0d", scen, tag, obs, exp);
    end
  endtask

  // reference model: spec rules with a queue history, newest bit at index 0
  logic [66:0] exp_q[$];
  bit     m_hist[$];
  int     m_mode;  // 0 hunt, 1 sync, 2 locked
  int     m_fill, m_match, m_wcnt, m_werr;
  longint m_bitc, m_errc;

  function automatic bit hist_all_zero();
    foreach (m_hist[i]) if (m_hist[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic longint sat_inc(input longint x);
    return (x < 64'h0000_0000_FFFF_FFFF) ? x + 1 : x;
  endfunction

  task automatic push_hist(input bit b);
    m_hist.push_front(b);
    void'(m_hist.pop_back());
  endtask

  task automatic model_step(input logic rst, input logic v, input logic s, input logic c);
    logic e, mis, err_p, loss_p;
    err_p = 1'b0;
    loss_p = 1'b0;
    if (!rst) begin
      m_hist.delete();
      for (int i = 0; i < LAG_B; i++) m_hist.push_back(1'b0);
      m_mode = 0; m_fill = 0; m_match = 0; m_wcnt = 0; m_werr = 0;
      m_bitc = 0; m_errc = 0;
    end else begin
      e = m_hist[LAG_A-1] ^ m_hist[LAG_B-1];
      if (c) begin m_bitc = 0; m_errc = 0; end
      if (v) begin
        case (m_mode)
          0: begin
            push_hist(s);
            m_fill++;
            if (m_fill == LAG_B) begin m_mode = 1; m_match = 0; end
          end
          1: begin
            m_match = (s == e) ? m_match + 1 : 0;
            push_hist(s);
            if (m_match == LOCK_N) begin
              if (hist_all_zero()) m_match = 0;
              else begin m_mode = 2; m_wcnt = 0; m_werr = 0; end
            end
          end
          default: begin
            mis = (s != e);
            push_hist(e);
            if (!c) begin
              m_bitc = sat_inc(m_bitc);
              if (mis) m_errc = sat_inc(m_errc);
            end
            if (mis) begin
              err_p = 1'b1;
              if (m_werr < LOSS_ERR) m_werr++;
              if (m_werr == LOSS_ERR) begin loss_p = 1'b1; m_mode = 0; m_fill = 0; end
            end
            m_wcnt++;
            if (m_wcnt == WIN) begin m_wcnt = 0; m_werr = 0; end
          end
        endcase
      end
    end
    exp_q.push_back({(m_mode == 2), err_p, loss_p, 32'(m_bitc), 32'(m_errc)});
  endtask

  // PRS generator, same recurrence as the team source
  logic [LAG_B-1:0] g;
  int bit_idx, err_pulses, loss_pulses;
  bit lock_seen;

  task automatic gen_bit(output logic b);
    b = g[LAG_A-1] ^ g[LAG_B-1];
    g = {g[LAG_B-2:0], b};
  endtask

  // driver: apply inputs, let one edge pass, then compare every output against the model
  task automatic drive(input logic rst, input logic v, input logic s, input logic c);
    logic [66:0] e;
    reset_n = rst; bus.i_vld = v; bus.i_sym = s; bus.i_clr = c;
    @(posedge clk);
    model_step(rst, v, s, c);
    #1;
    e = exp_q.pop_front();
    check("lock",    64'(bus.o_lock),    64'(e[66]));
    check("err",     64'(bus.o_err),     64'(e[65]));
    check("loss",    64'(bus.o_loss),    64'(e[64]));
    check("bit_cnt", 64'(bus.o_bit_cnt), 64'(e[63:32]));
    check("err_cnt", 64'(bus.o_err_cnt), 64'(e[31:0]));
    if (bus.o_lock) lock_seen = 1'b1;
    if (bus.o_err)  err_pulses++;
    if (bus.o_loss) loss_pulses++;
  endtask

  task automatic do_reset(input string name);
    scen = name;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    g = LAG_B'($urandom_range(1, (1 << LAG_B) - 1));
    bit_idx = 0; err_pulses = 0; loss_pulses = 0; lock_seen = 1'b0;
  endtask

  // send n generator bits, inverting indices inv_lo..inv_hi, with optional idle cycle before each bit
  task automatic send_gen(input int n, input bit gap, input int inv_lo, input int inv_hi);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen_bit(b);
      if (bit_idx >= inv_lo && bit_idx <= inv_hi) b = ~b;
      if (gap) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      drive(1'b1, 1'b1, b, 1'b0);
      bit_idx++;
    end
  endtask

  initial begin
    logic b;
    int burst;

    // 1) continuous loopback
    do_reset("s1");
    check("rst_state", 64'(dbg_state), 64'(HUNT));
    check("rst_bitcnt", 64'(bus.o_bit_cnt), 64'd0);
    send_gen(40, 1'b0, -1, -1);
    check("nolock40", 64'(bus.o_lock), 64'd0);
    send_gen(8, 1'b0, -1, -1);
    check("lock48", 64'(bus.o_lock), 64'd1);
    send_gen(10000 - 48, 1'b0, -1, -1);
    check("final_err_cnt", 64'(bus.o_err_cnt), 64'd0);
    check("final_bit_cnt", 64'(bus.o_bit_cnt), 64'(10000 - 48));

    // 2) gapped valid
    do_reset("s2");
    send_gen(48, 1'b1, -1, -1);
    check("lock48", 64'(bus.o_lock), 64'd1);
    send_gen(2000 - 48, 1'b1, -1, -1);
    check("final_err_cnt", 64'(bus.o_err_cnt), 64'd0);
    check("final_bit_cnt", 64'(bus.o_bit_cnt), 64'(2000 - 48));

    // 3) single error at locked bit 100
    do_reset("s3");
    send_gen(400, 1'b0, 48 + 100, 48 + 100);
    check("err_pulses", 64'(err_pulses), 64'd1);
    check("err_cnt", 64'(bus.o_err_cnt), 64'd1);
    check("lock_kept", 64'(bus.o_lock), 64'd1);
    check("bit_cnt", 64'(bus.o_bit_cnt), 64'(400 - 48));

    // 4) 32-bit burst inside the first window: loss, then relock 48 bits later
    do_reset("s4");
    send_gen(58 + 32, 1'b0, 58, 58 + 31);
    check("loss_now", 64'(bus.o_loss), 64'd1);
    check("unlocked", 64'(bus.o_lock), 64'd0);
    send_gen(300 - 90, 1'b0, -1, -1);
    check("loss_pulses", 64'(loss_pulses), 64'd1);
    check("relocked", 64'(bus.o_lock), 64'd1);
    check("err_cnt", 64'(bus.o_err_cnt), 64'd32);
    check("bit_cnt", 64'(bus.o_bit_cnt), 64'(42 + 162));

    // 5) all-zero input must never lock
    do_reset("s5");
    for (int i = 0; i < 200; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("never_locked", 64'(lock_seen), 64'd0);
    check("bit_cnt", 64'(bus.o_bit_cnt), 64'd0);
    check("err_cnt", 64'(bus.o_err_cnt), 64'd0);

    // 6) reset while locked; clear alongside a valid bit
    do_reset("s6");
    send_gen(60, 1'b0, 50, 50);
    gen_bit(b);
    drive(1'b0, 1'b1, b, 1'b0);
    check("rst_lock", 64'(bus.o_lock), 64'd0);
    check("rst_bit_cnt", 64'(bus.o_bit_cnt), 64'd0);
    check("rst_err_cnt", 64'(bus.o_err_cnt), 64'd0);
    send_gen(60, 1'b0, -1, -1);
    gen_bit(b);
    drive(1'b1, 1'b1, b, 1'b1);
    check("clr_lock", 64'(bus.o_lock), 64'd1);
    check("clr_bit_cnt", 64'(bus.o_bit_cnt), 64'd0);
    send_gen(5, 1'b0, -1, -1);
    check("post_clr_bit_cnt", 64'(bus.o_bit_cnt), 64'd5);

    // 7) random duty cycle, sparse errors, bursts and clears
    do_reset("s7");
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        gen_bit(b);
        if ($urandom_range(0, 999) == 0) burst = 40;
        if (burst > 0) begin b = ~b; burst--; end
        else if ($urandom_range(0, 99) == 0) b = ~b;
        drive(1'b1, 1'b1, b, 1'($urandom_range(0, 299) == 0));
      end else begin
        drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 299) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
